// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the requester FIFOs, the uart_tx arbiter and the uart_tx transmitter.
// The master side drives requests and transmitter ready; the slave side is the arbiter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   i_req_valid;
    logic [8*NUM_REQ-1:0] i_req_data;
    logic [NUM_REQ-1:0]   i_req_last;
    logic [NUM_REQ-1:0]   o_req_ready;
    logic [7:0]           o_tx_data;
    logic                 o_tx_valid;
    logic                 i_tx_ready;
    logic [NUM_REQ-1:0]   o_grant;
    logic                 o_busy;
    logic                 o_timeout;

    modport master (
        output i_req_valid, i_req_data, i_req_last, i_tx_ready,
        input  o_req_ready, o_tx_data, o_tx_valid, o_grant, o_busy, o_timeout
    );

    modport slave (
        input  i_req_valid, i_req_data, i_req_last, i_tx_ready,
        output o_req_ready, o_tx_data, o_tx_valid, o_grant, o_busy, o_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter sharing one uart_tx; UART_ARB_TIMEOUT_EN adds stall release.
// Latency: grant registered 1 cycle after request; bytes pass combinationally while locked.
// Backpressure: i_tx_ready feeds straight through to the owner's ready; all others see 0.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int MAX_BURST      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    uart_tx_arbiter_if.slave   bus
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam logic [CW-1:0] BURST_LAST = (MAX_BURST > 0) ? CW'(MAX_BURST - 1) : '0;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0]         state;
    logic [NUM_REQ-1:0] grant;
    logic [PW-1:0]      ptr;
    logic [CW-1:0]      burst_cnt;
    logic               timeout_q;

    logic               hi_vld, lo_vld, pick_vld;
    logic [PW-1:0]      hi_idx, lo_idx, pick_idx;
    logic [7:0]         sel_data;
    logic               sel_vld, sel_last;
    logic               xfer, burst_hit, stall_hit;

    // Search above the pointer first; fall back to the lowest index at or below it.
    always_comb begin
        hi_vld = 1'b0;
        hi_idx = '0;
        lo_vld = 1'b0;
        lo_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.i_req_valid[k]) begin
                if (k > int'(ptr)) begin
                    hi_vld = 1'b1;
                    hi_idx = PW'(k);
                end else begin
                    lo_vld = 1'b1;
                    lo_idx = PW'(k);
                end
            end
        end
        pick_vld = hi_vld | lo_vld;
        pick_idx = hi_vld ? hi_idx : lo_idx;
    end

    always_comb begin
        sel_data = '0;
        sel_vld  = 1'b0;
        sel_last = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                sel_data = bus.i_req_data[8*k +: 8];
                sel_vld  = bus.i_req_valid[k];
                sel_last = bus.i_req_last[k];
            end
        end
    end

    // Reset gates the handshake so an abandoned message cannot move a byte.
    assign bus.o_tx_data   = sel_data;
    assign bus.o_tx_valid  = i_rst_n & (state == ST_LOCK) & sel_vld;
    assign bus.o_req_ready = (i_rst_n && (state == ST_LOCK) && bus.i_tx_ready) ? grant : '0;
    assign bus.o_grant     = grant;
    assign bus.o_busy      = (state == ST_LOCK);
    assign bus.o_timeout   = timeout_q;

    assign xfer      = bus.o_tx_valid & bus.i_tx_ready;
    assign burst_hit = (MAX_BURST > 0) && (burst_cnt == BURST_LAST);

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] stall_cnt;

    assign stall_hit = (state == ST_LOCK) && !sel_vld && (stall_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            stall_cnt <= '0;
        end else if ((state != ST_LOCK) || sel_vld || stall_hit) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign stall_hit          = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            grant     <= '0;
            ptr       <= PW'(NUM_REQ - 1);
            burst_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    burst_cnt <= '0;
                    if (pick_vld) begin
                        state <= ST_LOCK;
                        grant <= NUM_REQ'(1) << pick_idx;
                        ptr   <= pick_idx;
                    end
                end
                ST_LOCK: begin
                    if (xfer && (sel_last || burst_hit)) begin
                        state     <= ST_IDLE;
                        grant     <= '0;
                        burst_cnt <= '0;
                    end else if (stall_hit) begin
                        // Pointer stays on the stalled owner so the others win next.
                        state     <= ST_IDLE;
                        grant     <= '0;
                        burst_cnt <= '0;
                        timeout_q <= 1'b1;
                    end else if (xfer && (burst_cnt != '1)) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queued requester messages, transfer log, hand-computed expectations.
module tb_uart_tx_arbiter;
    localparam int NR = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NR)) bus();

    uart_tx_arbiter #(
        .NUM_REQ(NR),
        .MAX_BURST(16),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    logic [8:0] srcq [NR][$];
    logic       hold [NR];
    logic [7:0] tx_log[$];
    logic [3:0] gnt_log[$];
    int         xcyc_log[$];
    int         cyc_n, tmo_pulses, n_checks, n_fail;

    logic [3:0] obs_grant, obs_ready;
    logic [7:0] obs_data;
    logic       obs_valid, obs_busy, obs_timeout;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        logic [NR-1:0]   v, l;
        logic [8*NR-1:0] d;
        logic [8:0]      h;
        v = '0;
        l = '0;
        d = '0;
        for (int k = 0; k < NR; k++) begin
            if (hold[k] && srcq[k].size() > 0) begin
                h = srcq[k][0];
                v[k] = 1'b1;
                l[k] = h[8];
                d[8*k +: 8] = h[7:0];
            end
        end
        bus.i_req_valid = v;
        bus.i_req_last  = l;
        bus.i_req_data  = d;
    endtask

    // One clock: drive heads, sample mid-cycle, log/pop handshakes, advance past the edge.
    task automatic cyc();
        drive();
        #4;
        obs_grant   = bus.o_grant;
        obs_ready   = bus.o_req_ready;
        obs_data    = bus.o_tx_data;
        obs_valid   = bus.o_tx_valid;
        obs_busy    = bus.o_busy;
        obs_timeout = bus.o_timeout;
        if (obs_timeout) tmo_pulses++;
        if (bus.o_tx_valid && bus.i_tx_ready) begin
            tx_log.push_back(bus.o_tx_data);
            gnt_log.push_back(bus.o_grant);
            xcyc_log.push_back(cyc_n);
        end
        for (int k = 0; k < NR; k++)
            if (bus.i_req_valid[k] && bus.o_req_ready[k]) void'(srcq[k].pop_front());
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic run_xfers(input int n, input int budget);
        for (int i = 0; i < budget && tx_log.size() < n; i++) cyc();
    endtask

    task automatic clear_logs();
        tx_log.delete();
        gnt_log.delete();
        xcyc_log.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int k = 0; k < NR; k++) begin
            srcq[k].delete();
            hold[k] = 1'b1;
        end
        bus.i_tx_ready = 1'b1;
        cyc();
        cyc();
        chk("rst_grant", obs_grant, 0);
        chk("rst_busy", obs_busy, 0);
        chk("rst_valid", obs_valid, 0);
        chk("rst_timeout", obs_timeout, 0);
        rst_n = 1'b1;
        clear_logs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, first_pulse;
        logic [3:0] g10;
        n_checks = 0;
        n_fail = 0;
        cyc_n = 0;
        tmo_pulses = 0;
        rst_n = 1'b0;
        bus.i_tx_ready = 1'b1;
        bus.i_req_valid = '0;
        bus.i_req_last = '0;
        bus.i_req_data = '0;
        for (int k = 0; k < NR; k++) hold[k] = 1'b1;
        @(posedge clk);
        #1;

        // 1: reset priority, requester 0 over 2, one idle cycle between grants
        do_reset();
        srcq[0].push_back(9'h041);
        srcq[0].push_back(9'h142);
        srcq[2].push_back(9'h15A);
        cyc(); chk("t1_c0_grant", obs_grant, 4'b0000);
        cyc(); chk("t1_c1_grant", obs_grant, 4'b0001);
        chk("t1_A", obs_data, 8'h41);
        chk("t1_A_valid", obs_valid, 1);
        cyc(); chk("t1_B", obs_data, 8'h42);
        cyc(); chk("t1_gap_grant", obs_grant, 4'b0000);
        chk("t1_gap_busy", obs_busy, 0);
        cyc(); chk("t1_grant2", obs_grant, 4'b0100);
        chk("t1_Z", obs_data, 8'h5A);
        cyc();

        // 2: round-robin over four single-byte messages
        do_reset();
        srcq[0].push_back(9'h110);
        srcq[0].push_back(9'h120);
        srcq[1].push_back(9'h111);
        srcq[2].push_back(9'h112);
        srcq[3].push_back(9'h113);
        run_xfers(5, 40);
        chk("t2_count", tx_log.size(), 5);
        chk("t2_g0", gnt_log[0], 4'b0001);
        chk("t2_g1", gnt_log[1], 4'b0010);
        chk("t2_g2", gnt_log[2], 4'b0100);
        chk("t2_g3", gnt_log[3], 4'b1000);
        chk("t2_g4", gnt_log[4], 4'b0001);
        chk("t2_d3", tx_log[3], 8'h13);
        chk("t2_d4", tx_log[4], 8'h20);

        // 3: 20-byte message split by the 16-byte burst limit
        clear_logs();
        for (int i = 0; i < 20; i++) srcq[1].push_back({(i == 19), 8'(8'h80 + i)});
        run_xfers(20, 80);
        chk("t3_count", tx_log.size(), 20);
        bad = 0;
        for (int i = 0; i < 20; i++) if (tx_log[i] !== 8'(8'h80 + i)) bad++;
        chk("t3_order", bad, 0);
        chk("t3_inburst_gap", xcyc_log[15] - xcyc_log[14], 1);
        chk("t3_release_gap", xcyc_log[16] - xcyc_log[15], 2);

        // 4: transmitter backpressure mid-message
        clear_logs();
        srcq[2].push_back(9'h060);
        srcq[2].push_back(9'h061);
        srcq[2].push_back(9'h162);
        run_xfers(1, 20);
        bus.i_tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t4_ready_low", obs_ready, 4'b0000);
            chk("t4_data_hold", obs_data, 8'h61);
        end
        chk("t4_stalled_count", tx_log.size(), 1);
        bus.i_tx_ready = 1'b1;
        run_xfers(3, 20);
        chk("t4_count", tx_log.size(), 3);
        chk("t4_d1", tx_log[1], 8'h61);
        chk("t4_d2", tx_log[2], 8'h62);

        // 5: reset during byte 3 of 6; requester 0 wins afterwards
        clear_logs();
        for (int i = 0; i < 6; i++) srcq[3].push_back({(i == 5), 8'(8'h30 + i)});
        srcq[0].push_back(9'h140);
        run_xfers(2, 20);
        chk("t5_pre_owner", gnt_log[0], 4'b1000);
        rst_n = 1'b0;
        cyc();
        chk("t5_rst_valid", obs_valid, 0);
        chk("t5_rst_ready", obs_ready, 4'b0000);
        rst_n = 1'b1;
        cyc();
        chk("t5_after_grant", obs_grant, 4'b0000);
        chk("t5_after_busy", obs_busy, 0);
        chk("t5_after_valid", obs_valid, 0);
        cyc();
        chk("t5_first_owner", obs_grant, 4'b0001);
        run_xfers(7, 40);
        chk("t5_count", tx_log.size(), 7);
        chk("t5_d2", tx_log[2], 8'h40);
        chk("t5_d3", tx_log[3], 8'h32);
        chk("t5_d6", tx_log[6], 8'h35);

        // 6: owner drops valid mid-message
        do_reset();
        srcq[1].push_back(9'h050);
        srcq[1].push_back(9'h051);
        srcq[1].push_back(9'h152);
        srcq[3].push_back(9'h170);
        run_xfers(1, 10);
        chk("t6_first", tx_log[0], 8'h50);
        hold[1] = 1'b0;
        tmo_pulses = 0;
        first_pulse = -1;
        g10 = '0;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            if (obs_timeout && first_pulse < 0) first_pulse = i;
            if (i == 10) g10 = obs_grant;
        end
        hold[1] = 1'b1;
        run_xfers(4, 30);
        chk("t6_count", tx_log.size(), 4);
`ifdef UART_ARB_TIMEOUT_EN
        chk("t6_pulses", tmo_pulses, 1);
        chk("t6_pulse_cycle", first_pulse, 9);
        chk("t6_new_owner", g10, 4'b1000);
        chk("t6_d1", tx_log[1], 8'h70);
        chk("t6_d2", tx_log[2], 8'h51);
        chk("t6_d3", tx_log[3], 8'h52);
`else
        chk("t6_pulses", tmo_pulses, 0);
        chk("t6_held_owner", g10, 4'b0010);
        chk("t6_d1", tx_log[1], 8'h51);
        chk("t6_d2", tx_log[2], 8'h52);
        chk("t6_d3", tx_log[3], 8'h70);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
